kernel_loader: RTL

//  Upstream write-side feeder for the kernel memory. Accepts a narrow stream of
//  KER_WIDTH kernel coefficients and packs GROUP_NB of them into one wide word.

---
 rtl/kernel_loader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/kernel_loader.sv
// kernel_loader: packs GROUP_NB narrow kernel coefficients per wide word and writes cfg_len words to kernel memory.
// Optional build macro: KERNEL_LOADER_CHECKSUM_EN adds a chk_sum output (modulo sum of accepted coefficients).
module kernel_loader #(
    parameter int GROUP_NB   = 4,
    parameter int KER_WIDTH  = 16,
    parameter int MEM_AWIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MEM_AWIDTH-1:0]         cfg_addr,
    input  logic [MEM_AWIDTH-1:0]         cfg_len,
    input  logic                          cfg_start,
    output logic                          cfg_busy,
    output logic                          cfg_done,
    input  logic [KER_WIDTH-1:0]          ker_data,
    input  logic                          ker_val,
    output logic                          ker_rdy,
    output logic [MEM_AWIDTH-1:0]         wr_addr,
    output logic                          wr_addr_set,
    output logic [GROUP_NB*KER_WIDTH-1:0] wr_data,
    output logic                          wr_data_val,
    input  logic                          wr_data_rdy
`ifdef KERNEL_LOADER_CHECKSUM_EN
    ,
    output logic [KER_WIDTH-1:0]          chk_sum
`endif
);
    localparam int LW = GROUP_NB > 1 ? $clog2(GROUP_NB) : 1;
    localparam int DW = GROUP_NB * KER_WIDTH;

    typedef enum logic [2:0] {IDLE, SET, PACK, PUSH, DONE} state_t;

    state_t                state_q, state_d;
    logic [MEM_AWIDTH-1:0] addr_q, addr_d;
    logic [MEM_AWIDTH-1:0] len_q, len_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic [DW-1:0]         pack_q, pack_d;
    logic [DW-1:0]         data_q, data_d;
    logic                  ker_fire, wr_fire, last_lane;
`ifdef KERNEL_LOADER_CHECKSUM_EN
    logic [KER_WIDTH-1:0]  chk_q, chk_d;
    assign chk_sum = chk_q;
`endif

    assign cfg_busy    = state_q != IDLE;
    assign cfg_done    = state_q == DONE;
    assign ker_rdy     = state_q == PACK;
    assign wr_addr_set = state_q == SET;
    assign wr_data_val = state_q == PUSH;
    assign wr_addr     = addr_q;
    assign wr_data     = data_q;
    assign ker_fire    = ker_val & ker_rdy;
    assign wr_fire     = wr_data_val & wr_data_rdy;
    assign last_lane   = lane_q == LW'(GROUP_NB - 1);

    // Next-state logic: sequencing, lane packing, word hand-off and remaining-word count.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        lane_d  = lane_q;
        pack_d  = pack_q;
        data_d  = data_q;
`ifdef KERNEL_LOADER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            IDLE: if (cfg_start) begin
                len_d = cfg_len;
`ifdef KERNEL_LOADER_CHECKSUM_EN
                chk_d = '0;
`endif
                if (cfg_len == '0) begin
                    state_d = DONE;
                end else begin
                    addr_d  = cfg_addr;
                    state_d = SET;
                end
            end
            SET: begin
                lane_d  = '0;
                state_d = PACK;
            end
            PACK: if (ker_fire) begin
                for (int k = 0; k < GROUP_NB; k++)
                    if (lane_q == LW'(k)) pack_d[k*KER_WIDTH +: KER_WIDTH] = ker_data;
`ifdef KERNEL_LOADER_CHECKSUM_EN
                chk_d = chk_q + ker_data;
`endif
                lane_d = last_lane ? '0 : lane_q + LW'(1);
                if (last_lane) begin
                    data_d  = pack_d;
                    state_d = PUSH;
                end
            end
            PUSH: if (wr_fire) begin
                len_d   = len_q - MEM_AWIDTH'(1);
                state_d = len_q == MEM_AWIDTH'(1) ? DONE : PACK;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial pack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            lane_q  <= '0;
            pack_q  <= '0;
            data_q  <= '0;
`ifdef KERNEL_LOADER_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            lane_q  <= lane_d;
            pack_q  <= pack_d;
            data_q  <= data_d;
`ifdef KERNEL_LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end
endmodule
